// File: rtl/deser_queue_pkg.sv
// deser_queue_pkg: default constants shared by the deserializer/queue bridge
// and a helper for sizing occupancy counters.
package deser_queue_pkg;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_DESER_DIV = 10;
  localparam int DEF_QUEUE_DIV = 100;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle enable every DIV clk cycles.
//   clk   - system clock
//   rst_n - async active-low reset
//   tick  - high for one clk while the counter sits at DIV-1
// The counter starts at 0, so the first tick is sampled DIV edges after reset.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/deser_queue_bridge.sv
// deser_queue_bridge: serial-to-word deserializer feeding a DEPTH-entry FIFO,
// drained at a slower dequeue rate. All rates are clk enables from tick_gen.
//   clk, rst_n   - system clock, async active-low reset
//   data_in      - serial bit, taken on ser_tick when write_in && status_out
//   write_in     - serial bit valid
//   dequeue_in   - pop request, taken on q_tick
//   data_out     - last popped word;  data_valid - one-cycle pulse on pop
//   len_out      - words stored;  full / empty - occupancy flags
//   status_out   - 1 accepting bits, 0 holding a completed word
//   overflow     - sticky, a valid bit arrived while holding with FIFO full
module deser_queue_bridge
  import deser_queue_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DESER_DIV = DEF_DESER_DIV,
  parameter int QUEUE_DIV = DEF_QUEUE_DIV,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_in,
  input  logic                        write_in,
  input  logic                        dequeue_in,
  output logic [WIDTH-1:0]            data_out,
  output logic                        data_valid,
  output logic [cnt_w(DEPTH)-1:0]     len_out,
  output logic                        full,
  output logic                        empty,
  output logic                        status_out,
  output logic                        overflow
);
  localparam int LW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);

  logic             ser_tick, q_tick;
  logic [WIDTH-1:0] shreg, shift_nxt, pend_word;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    len_nxt;
  logic             accept, pop, push;

  tick_gen #(.DIV(DESER_DIV)) u_ser_tick (.clk(clk), .rst_n(rst_n), .tick(ser_tick));
  tick_gen #(.DIV(QUEUE_DIV)) u_q_tick   (.clk(clk), .rst_n(rst_n), .tick(q_tick));

  // status_out doubles as the inverse of "word pending".
  assign accept = ser_tick & write_in & status_out;
  assign pop    = q_tick & dequeue_in & ~empty;
  // A pop in the same cycle frees the slot even when full.
  assign push   = ~status_out & (~full | pop);

  always_comb begin
    if (MSB_FIRST) shift_nxt = {shreg[WIDTH-2:0], data_in};
    else           shift_nxt = {data_in, shreg[WIDTH-1:1]};
  end

  always_comb begin
    len_nxt = len_out;
    if (push && !pop)      len_nxt = len_out + 1'b1;
    else if (pop && !push) len_nxt = len_out - 1'b1;
  end

  // Deserializer and hold stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      pend_word  <= '0;
      status_out <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= shift_nxt;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= '0;
          pend_word  <= shift_nxt;
          status_out <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (push) status_out <= 1'b1;
      if (ser_tick && write_in && !status_out && full) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; only pointers and counts are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pend_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len_out    <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      len_out <= len_nxt;
      full    <= (len_nxt == LEN_FULL);
      empty   <= (len_nxt == '0);
    end
  end
endmodule

// File: tb/tb_deser_queue_bridge.sv
module tb_deser_queue_bridge;
  localparam int W = 8, D = 4, SDIV = 4, QDIV = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic data_in = 1'b0, write_in = 1'b0, dequeue_in = 1'b0;
  logic [W-1:0] dout0, dout1;
  logic         dv0, dv1, full0, full1, empty0, empty1, st0, st1, ovf0, ovf1;
  logic [2:0]   len0, len1;

  int checks = 0, failures = 0;
  int unsigned cyc;
  logic [W-1:0] sb0[$], sb1[$];
  logic [W-1:0] last0, last1;
  int max_len;

  always #5 clk = ~clk;

  deser_queue_bridge #(.WIDTH(W), .DEPTH(D), .DESER_DIV(SDIV), .QUEUE_DIV(QDIV), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_in(write_in), .dequeue_in(dequeue_in),
    .data_out(dout0), .data_valid(dv0), .len_out(len0), .full(full0), .empty(empty0),
    .status_out(st0), .overflow(ovf0));

  deser_queue_bridge #(.WIDTH(W), .DEPTH(D), .DESER_DIV(SDIV), .QUEUE_DIV(QDIV), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_in(write_in), .dequeue_in(dequeue_in),
    .data_out(dout1), .data_valid(dv1), .len_out(len1), .full(full1), .empty(empty1),
    .status_out(st1), .overflow(ovf1));

  // Bench-side cycle count since reset release; tick k is sampled on the edge
  // whose pre-edge count satisfies cyc % DIV == DIV-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) if (int'(len0) > max_len) max_len = int'(len0);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [W-1:0] rev8(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic wait_tick(input int div);
    @(negedge clk);
    while ((cyc % div) != div - 1) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; write_in = 1'b0; dequeue_in = 1'b0; data_in = 1'b0;
    sb0.delete(); sb1.delete();
    last0 = '0; last1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    wait_tick(SDIV);
    data_in = b; write_in = 1'b1;
    @(negedge clk);
    write_in = 1'b0; data_in = 1'b0;
  endtask

  // Bits go out w[0] first: the LSB-first instance rebuilds w, MSB-first rev8(w).
  task automatic send_word(input logic [W-1:0] w, input bit expect_push);
    for (int i = 0; i < W; i++) send_bit(w[i]);
    @(negedge clk);
    if (expect_push) begin
      sb0.push_back(w); sb1.push_back(rev8(w));
    end
  endtask

  task automatic do_pop();
    logic [W-1:0] e0, e1;
    wait_tick(QDIV);
    dequeue_in = 1'b1;
    @(negedge clk);
    dequeue_in = 1'b0;
    checks++;
    if (dv0 !== 1'b1 || dv1 !== 1'b1) begin
      failures++; $display("FAIL pop_valid got %b/%b want 1/1", dv0, dv1);
    end
    checks++;
    if (sb0.size() == 0) begin
      failures++; $display("FAIL pop_sb got data %h want <no word expected>", dout0);
    end else begin
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      last0 = e0; last1 = e1;
      if (dout0 !== e0 || dout1 !== e1) begin
        failures++; $display("FAIL pop_data got %h/%h want %h/%h", dout0, dout1, e0, e1);
      end
    end
    @(negedge clk);
    checks++;
    if (dv0 !== 1'b0) begin
      failures++; $display("FAIL pop_pulse_width got %b want 0", dv0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dout0 !== 8'h00 || dv0 !== 1'b0 || len0 !== 3'd0 || full0 !== 1'b0 ||
        empty0 !== 1'b1 || st0 !== 1'b1 || ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got dout=%h dv=%b len=%0d full=%b empty=%b st=%b ovf=%b want 00 0 0 0 1 1 0",
               dout0, dv0, len0, full0, empty0, st0, ovf0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_order();
    apply_reset();
    checks++;
    if (len0 !== 3'd0) begin failures++; $display("FAIL basic_len0 got %0d want 0", len0); end
    send_word(8'h4D, 1'b1); // stream 1,0,1,1,0,0,1,0
    checks++;
    if (len0 !== 3'd1 || empty0 !== 1'b0) begin
      failures++; $display("FAIL basic_len1 got len=%0d empty=%b want 1 0", len0, empty0);
    end
    checks++;
    if (sb1[0] !== 8'hB2) begin failures++; $display("FAIL msb_model got %h want b2", sb1[0]); end
    do_pop();
    checks++;
    if (len0 !== 3'd0 || empty0 !== 1'b1 || ovf0 !== 1'b0) begin
      failures++; $display("FAIL basic_drain got len=%0d empty=%b ovf=%b want 0 1 0", len0, empty0, ovf0);
    end
  endtask

  task automatic test_full_hold();
    apply_reset();
    for (int i = 1; i <= 4; i++) send_word(W'(i), 1'b1);
    checks++;
    if (full0 !== 1'b1 || len0 !== 3'd4 || st0 !== 1'b1) begin
      failures++; $display("FAIL full_flag got full=%b len=%0d st=%b want 1 4 1", full0, len0, st0);
    end
    send_word(8'h05, 1'b1);
    checks++;
    if (st0 !== 1'b0 || len0 !== 3'd4 || ovf0 !== 1'b0) begin
      failures++; $display("FAIL hold_state got st=%b len=%0d ovf=%b want 0 4 0", st0, len0, ovf0);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || st0 !== 1'b0) begin
      failures++; $display("FAIL overflow got ovf=%b/%b st=%b want 1/1 0", ovf0, ovf1, st0);
    end
    do_pop(); // 01 out, held 05 pushed on the same edge
    checks++;
    if (len0 !== 3'd4 || full0 !== 1'b1 || st0 !== 1'b1) begin
      failures++; $display("FAIL push_on_pop got len=%0d full=%b st=%b want 4 1 1", len0, full0, st0);
    end
    repeat (4) do_pop();
    checks++;
    if (len0 !== 3'd0 || empty0 !== 1'b1 || ovf0 !== 1'b1) begin
      failures++; $display("FAIL full_drain got len=%0d empty=%b ovf=%b want 0 1 1", len0, empty0, ovf0);
    end
  endtask

  task automatic test_empty_pop();
    for (int k = 0; k < 3; k++) begin
      wait_tick(QDIV);
      dequeue_in = 1'b1;
      @(negedge clk);
      dequeue_in = 1'b0;
      checks++;
      if (dv0 !== 1'b0 || dout0 !== last0 || dout1 !== last1 || len0 !== 3'd0) begin
        failures++;
        $display("FAIL empty_pop got dv=%b dout=%h/%h len=%0d want 0 %h/%h 0",
                 dv0, dout0, dout1, len0, last0, last1);
      end
    end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    apply_reset();
    checks++;
    if (len0 !== 3'd0 || st0 !== 1'b1 || ovf0 !== 1'b0 || dout0 !== 8'h00) begin
      failures++; $display("FAIL midword_reset got len=%0d st=%b ovf=%b dout=%h want 0 1 0 00",
                           len0, st0, ovf0, dout0);
    end
    send_word(8'hA5, 1'b1);
    checks++;
    if (len0 !== 3'd1) begin failures++; $display("FAIL midword_len got %0d want 1", len0); end
    do_pop();
    checks++;
    if (ovf0 !== 1'b0) begin failures++; $display("FAIL midword_ovf got %b want 0", ovf0); end
  endtask

  task automatic test_wrap();
    apply_reset();
    max_len = 0;
    for (int i = 0; i < 10; i++) begin
      send_word(W'(8'h10 + i), 1'b1);
      if (i >= 1) do_pop();
    end
    do_pop();
    checks++;
    if (len0 !== 3'd0 || sb0.size() != 0) begin
      failures++; $display("FAIL wrap_drain got len=%0d left=%0d want 0 0", len0, sb0.size());
    end
    checks++;
    if (max_len > D) begin failures++; $display("FAIL wrap_maxlen got %0d want <=%0d", max_len, D); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_full_hold();
    test_empty_pop();
    test_reset_midword();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
